bp_cce_mem_to_wb_burst: RTL
===========================

// Module: bp_cce_mem_to_wb_burst
// PURPOSE
//  Memory-side endpoint of the BlackParrot DRAM path. Consumes bp_cce_mem_msg_s commands that the
//  MMIO/DRAM split has steered to DRAM and masters a 64-bit Wishbone B4 bus toward the LiteX SoC.
//  Moves full cache blocks as incrementing bursts and uncached words as single cycles.
//  Returns one bp_cce_mem_msg_s response per command.
// PARAMETERS
//  cfg_p             e_bp_single_core_cfg  proc config; supplies paddr_width_p=40, cce_block_width_p=512
//  timeout_cycles_p  1024                  max cycles a beat waits for ack/err before forced abort
//  err_cnt_width_p   16                    width of saturating bus-error counter
// PORTS
//  clk_i             in   1     single clock
//  reset_n_i         in   1     asynchronous, active-low reset
//  mem_cmd_i         in   msg   bp_cce_mem_msg_s: msg_type, addr, size, payload, data[511:0]
//  mem_cmd_v_i       in   1     command valid
//  mem_cmd_yumi_o    out  1     command consumed this cycle
//  mem_resp_o        out  msg   response: header echoed from cmd; data filled on reads
//  mem_resp_v_o      out  1     response valid
//  mem_resp_ready_i  in   1     consumer ready
//  wbm_adr_o         out  37    64-bit word address = addr[39:3]
//  wbm_dat_o / _i    out/in 64  write / read data
//  wbm_sel_o         out  8     byte lane enables
//  wbm_cyc_o, wbm_stb_o, wbm_we_o  out 1 each   Wishbone strobes
//  wbm_cti_o         out  3     000 classic, 010 incrementing burst, 111 end-of-burst
//  wbm_bte_o         out  2     always 2'b00 (linear)
//  wbm_ack_i, wbm_err_i  in 1 each  beat terminate / error terminate
//  busy_o            out  1     state != IDLE
//  err_count_o       out  err_cnt_width_p   saturating count of err/timeout beats
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE, beat cnt=0, err_count_o=0.
//  Reset asserted mid-transfer drops cyc/stb in the same cycle. No response is produced.
//  FSM: IDLE -> BUS -> RESP -> IDLE.
//   IDLE: mem_cmd_yumi_o = mem_cmd_v_i (combinational). On yumi, latch the header and data.
//         Compute beats = (size_bytes<=8) ? 1 : size_bytes/8. Go to BUS next cycle.
//   BUS: cyc=stb=1 starting the first cycle after yumi. Beat k address = {addr[39:3]} + k.
//        Block addresses are size-aligned; the low offset is ignored for multi-beat transfers.
//        cti = 000 when beats==1. Otherwise 010 for beats 0..n-2 and 111 for the last beat.
//        Beat completes on ack_i|err_i|timeout. The next beat is driven the following cycle
//        with stb held high, so there is no idle gap. After the last beat: cyc=stb=0, go to RESP.
//   RESP: mem_resp_v_o=1, held stable until mem_resp_ready_i. Then IDLE.
//         A new cmd may be yumi'd no earlier than the cycle after the handshake.
//  Writes: we=1.
//   Multi-beat: beat k sends data[64k+:64] with sel=8'hFF.
//   Sub-8-byte: dat_o = data[63:0] << 8*addr[2:0]; sel = ((1<<size_bytes)-1) << addr[2:0].
//  Reads: we=0, sel as for writes.
//   Beat k's rdata is captured into resp data[64k+:64] on ack.
//   Sub-word reads are right-justified ((dat_i >> 8*addr[2:0]) masked to size_bytes); upper bits 0.
//  Err/timeout: err_i, or the timer reaching timeout_cycles_p with no ack/err, terminates the beat.
//   Read data for that beat is 0. err_count_o increments, saturating at all-ones.
//   The remaining beats still run and the response is still returned.
//   Timer resets at each beat start.
//   Simultaneous ack_i and err_i counts as an error.
//  Latency: single-beat read with 0-wait slave gives yumi@T, stb@T+1, ack@T+1, resp_v@T+2.
//  8-beat block: resp_v at T+9 minimum.
// STRUCTURE
//  bp_wb_pkg (shared): state enum {IDLE,BUS,RESP}; cti constants CLASSIC/INCR/EOB;
//   function size_to_bytes(size), function sel_mask(size,off).
//  Sub-module bp_wb_block_gearbox: 512-bit buffer with 3-bit beat index.
//   Provides write slice out and read slice in; one per instance.
//  Timeout timer and beat counter stay inline.
// TESTING
//  1 Uncached 8B read addr 0x8000_0010 -> adr=0x1000_0002, sel=FF, cti=000.
//    Slave returns 0xDEAD_BEEF_0123_4567 -> resp data[63:0] equals it, upper bits 0.
//  2 1B write addr 0x8000_0003, data 0xA5 -> sel=8'h08, dat_o[31:24]=A5, one beat, resp echoes header.
//  3 64B read addr 0x8000_0040 -> 8 beats adr 0x1000_0008..0x1000_000F, cti 010 x7 then 111.
//    Slave data k=0..7 equal to k -> resp data[64k+:64]=k.
//  4 64B write with 2-cycle ack stalls per beat; mem_resp_ready_i low 5 cycles.
//    -> stb held through stalls, resp_v and resp stable for 5 cycles, no second yumi meanwhile.
//  5 err_i on beat 3 of a read; a later beat is never acked -> beat 3 data 0.
//    Timeout after 1024 cycles, err_count_o=2, resp still returned.
//  6 reset_n_i pulled low during beat 4 of a burst -> cyc/stb/resp_v=0 immediately.
//    After release, a fresh cmd completes normally.

Source files
------------

// File: rtl/bp_cce_mem_to_wb_burst_pkg.sv
// Shared types and helpers for the BlackParrot memory-message to Wishbone bridge.
// Holds the mem message layout, FSM state enum, Wishbone CTI codes, and the
// size/byte-lane helper functions used by the bridge datapath.
package bp_wb_pkg;

   typedef enum logic [3:0] {
      e_bp_single_core_cfg = 4'd0
   } bp_cfg_e;

   localparam int paddr_width_lp   = 40;
   localparam int block_width_lp   = 512;
   localparam int payload_width_lp = 16;

   function automatic int cfg_paddr_width(bp_cfg_e cfg);
      case (cfg)
         e_bp_single_core_cfg: return paddr_width_lp;
         default:              return paddr_width_lp;
      endcase
   endfunction

   typedef enum logic [3:0] {
      e_mem_rd    = 4'd0,
      e_mem_wr    = 4'd1,
      e_mem_uc_rd = 4'd2,
      e_mem_uc_wr = 4'd3
   } mem_msg_type_e;

   // size encodes log2(bytes): 0=1B ... 6=64B
   typedef struct packed {
      mem_msg_type_e               msg_type;
      logic [paddr_width_lp-1:0]   addr;
      logic [2:0]                  size;
      logic [payload_width_lp-1:0] payload;
      logic [block_width_lp-1:0]   data;
   } mem_msg_s;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Encodings above 64B are clamped to a full block.
   function automatic logic [6:0] size_to_bytes(logic [2:0] size);
      return (size >= 3'd6) ? 7'd64 : 7'(32'd1 << size);
   endfunction

   function automatic logic [7:0] sel_mask(logic [2:0] size, logic [2:0] off);
      logic [6:0]  bytes;
      logic [15:0] m;
      bytes = size_to_bytes(size);
      if (bytes >= 7'd8) m = 16'h00FF;
      else               m = (16'd1 << bytes) - 16'd1;
      m = m << off;
      return m[7:0];
   endfunction

   // Right-justify a sub-word read and clear bytes beyond the access size.
   function automatic logic [63:0] rd_justify(logic [63:0] dat, logic [2:0] size, logic [2:0] off);
      logic [6:0]  bytes;
      logic [63:0] mask;
      bytes = size_to_bytes(size);
      mask  = '1;
      if (bytes < 7'd8) mask = (64'd1 << {bytes[2:0], 3'b000}) - 64'd1;
      return (dat >> {off, 3'b000}) & mask;
   endfunction

endpackage

// File: rtl/bp_cce_mem_to_wb_burst_if.sv
// Bus bundles for the bridge.
//  bp_cce_mem_if: command in (cmd, cmd_v, cmd_yumi) and response out
//                 (resp, resp_v, resp_ready). slave = the bridge side.
//  bp_wb_if:      64-bit Wishbone B4 with burst tags (cti/bte).
//                 master = the bridge side.
interface bp_cce_mem_if;
   bp_wb_pkg::mem_msg_s cmd;
   logic                cmd_v;
   logic                cmd_yumi;
   bp_wb_pkg::mem_msg_s resp;
   logic                resp_v;
   logic                resp_ready;

   modport master (output cmd, cmd_v, resp_ready, input cmd_yumi, resp, resp_v);
   modport slave  (input cmd, cmd_v, resp_ready, output cmd_yumi, resp, resp_v);
endinterface

interface bp_wb_if;
   logic [36:0] adr;
   logic [63:0] dat_w;
   logic [63:0] dat_r;
   logic [7:0]  sel;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;

   modport master (output adr, dat_w, sel, cyc, stb, we, cti, bte, input dat_r, ack, err);
   modport slave  (input adr, dat_w, sel, cyc, stb, we, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/bp_cce_mem_to_wb_burst_gearbox.sv
// bp_wb_block_gearbox: 512-bit block buffer addressed as eight 64-bit beats.
//  load_i/load_data_i : overwrite the whole block
//  idx_i              : current beat index
//  wr_slice_o         : beat idx_i of the block (write data out)
//  rd_v_i/rd_slice_i  : store a beat of read data at idx_i
//  block_o            : whole block
module bp_wb_block_gearbox (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         load_i,
   input  logic [511:0] load_data_i,
   input  logic [2:0]   idx_i,
   input  logic         rd_v_i,
   input  logic [63:0]  rd_slice_i,
   output logic [63:0]  wr_slice_o,
   output logic [511:0] block_o
);
   genvar gi;
   for (gi = 0; gi < 8; gi++) begin : g_slice
      logic [63:0] slice_reg;
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i)                         slice_reg <= '0;
         else if (load_i)                        slice_reg <= load_data_i[64*gi +: 64];
         else if (rd_v_i && (idx_i == 3'(gi)))   slice_reg <= rd_slice_i;
      end
      assign block_o[64*gi +: 64] = slice_reg;
   end

   assign wr_slice_o = block_o[{idx_i, 6'd0} +: 64];
endmodule

// File: rtl/bp_cce_mem_to_wb_burst.sv
// bp_cce_mem_to_wb_burst: executes DRAM-bound mem commands on a Wishbone bus.
// Full blocks go out as incrementing bursts, sub-block accesses as one
// classic cycle; exactly one response is returned per command.
//  clk_i, reset_n_i : clock, asynchronous active-low reset
//  mem              : command / response channel (slave side)
//  wbm              : Wishbone master
//  busy_o           : a command is in flight
//  err_count_o      : saturating count of beats ended by err or timeout
module bp_cce_mem_to_wb_burst
   import bp_wb_pkg::*;
#(
   parameter bp_cfg_e cfg_p            = e_bp_single_core_cfg,
   parameter int      timeout_cycles_p = 1024,
   parameter int      err_cnt_width_p  = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   bp_cce_mem_if.slave                mem,
   bp_wb_if.master                    wbm,
   output logic                       busy_o,
   output logic [err_cnt_width_p-1:0] err_count_o
);
   localparam int paddr_w_lp = cfg_paddr_width(cfg_p);
   localparam int timer_w_lp = $clog2(timeout_cycles_p) + 1;

   state_e                       state_reg, state_next;
   mem_msg_type_e                msg_type_reg;
   logic [paddr_w_lp-1:0]        addr_reg;
   logic [2:0]                   size_reg;
   logic [payload_width_lp-1:0]  payload_reg;
   logic [2:0]                   beat_reg, last_beat_reg;
   logic [timer_w_lp-1:0]        timer_reg;
   logic [err_cnt_width_p-1:0]   err_cnt_reg;

   logic         yumi, bus_on, resp_v;
   logic         is_write, cmd_is_write, single, timeout, beat_err, beat_done;
   logic [6:0]   cmd_bytes;
   logic [63:0]  wr_slice, rd_slice;
   logic [511:0] block;
   mem_msg_s     resp_s;

   assign is_write     = (msg_type_reg == e_mem_wr) || (msg_type_reg == e_mem_uc_wr);
   assign cmd_is_write = (mem.cmd.msg_type == e_mem_wr) || (mem.cmd.msg_type == e_mem_uc_wr);
   assign cmd_bytes    = size_to_bytes(mem.cmd.size);
   assign single       = (last_beat_reg == 3'd0);
   assign timeout      = (timer_reg == timer_w_lp'(timeout_cycles_p - 1));
   // ack together with err is treated as an error
   assign beat_err     = wbm.err | timeout;
   assign beat_done    = (state_reg == BUS) & (wbm.ack | beat_err);

   always_comb begin
      state_next = state_reg;
      yumi       = 1'b0;
      bus_on     = 1'b0;
      resp_v     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            // gated by reset so nothing is consumed while held in reset
            if (mem.cmd_v && reset_n_i) begin
               yumi       = 1'b1;
               state_next = BUS;
            end
         end
         BUS: begin
            bus_on = 1'b1;
            if (beat_done && (beat_reg == last_beat_reg)) state_next = RESP;
         end
         RESP: begin
            resp_v = 1'b1;
            if (mem.resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg     <= IDLE;
         msg_type_reg  <= e_mem_rd;
         addr_reg      <= '0;
         size_reg      <= '0;
         payload_reg   <= '0;
         beat_reg      <= '0;
         last_beat_reg <= '0;
         timer_reg     <= '0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (yumi) begin
            msg_type_reg  <= mem.cmd.msg_type;
            addr_reg      <= mem.cmd.addr;
            size_reg      <= mem.cmd.size;
            payload_reg   <= mem.cmd.payload;
            beat_reg      <= '0;
            timer_reg     <= '0;
            last_beat_reg <= (cmd_bytes <= 7'd8) ? 3'd0 : 3'((cmd_bytes >> 3) - 7'd1);
         end else if (state_reg == BUS) begin
            if (beat_done) begin
               timer_reg <= '0;
               beat_reg  <= beat_reg + 3'd1;
            end else begin
               timer_reg <= timer_reg + 1'b1;
            end
         end
         if (beat_done && beat_err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   // Read commands start from a cleared buffer so unfilled bits return 0.
   assign rd_slice = beat_err ? 64'd0 :
                     single   ? rd_justify(wbm.dat_r, size_reg, addr_reg[2:0]) : wbm.dat_r;

   bp_wb_block_gearbox u_gearbox (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .load_i      (yumi),
      .load_data_i (cmd_is_write ? mem.cmd.data : 512'd0),
      .idx_i       (beat_reg),
      .rd_v_i      (beat_done & ~is_write),
      .rd_slice_i  (rd_slice),
      .wr_slice_o  (wr_slice),
      .block_o     (block)
   );

   always_comb begin
      wbm.adr   = '0;
      wbm.dat_w = '0;
      wbm.sel   = '0;
      wbm.we    = 1'b0;
      wbm.cti   = CTI_CLASSIC;
      wbm.bte   = 2'b00;
      if (bus_on) begin
         wbm.adr   = addr_reg[paddr_w_lp-1:3] + 37'(beat_reg);
         wbm.we    = is_write;
         wbm.dat_w = single ? (wr_slice << {addr_reg[2:0], 3'b000}) : wr_slice;
         wbm.sel   = single ? sel_mask(size_reg, addr_reg[2:0]) : 8'hFF;
         wbm.cti   = single ? CTI_CLASSIC : ((beat_reg == last_beat_reg) ? CTI_EOB : CTI_INCR);
      end
   end

   always_comb begin
      resp_s          = '0;
      resp_s.msg_type = msg_type_reg;
      resp_s.addr     = addr_reg;
      resp_s.size     = size_reg;
      resp_s.payload  = payload_reg;
      resp_s.data     = is_write ? 512'd0 : block;
   end

   assign mem.cmd_yumi = yumi;
   assign mem.resp     = resp_s;
   assign mem.resp_v   = resp_v;
   assign wbm.cyc      = bus_on;
   assign wbm.stb      = bus_on;
   assign busy_o       = (state_reg != IDLE);
   assign err_count_o  = err_cnt_reg;
endmodule
